// File: rtl/tmds10b8b_align_dec.sv
// TMDS receive channel decoder: recovers 10-bit word alignment by bit-slipping
// until control tokens line up, then decodes words to pixel data or control state.
module tmds10b8b_align_dec #(
  parameter int unsigned SEARCH_WIN = 2048,
  parameter int unsigned TOKEN_RUN  = 8,
  parameter int unsigned SLIP_WAIT  = 4,
  parameter int unsigned LOSS_WIN   = 4096
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [9:0] din,
  output logic [7:0] dout,
  output logic       de,
  output logic       c0,
  output logic       c1,
  output logic       locked,
  output logic       bitslip
);

  localparam int unsigned MAX_WIN = (SEARCH_WIN > LOSS_WIN) ? SEARCH_WIN : LOSS_WIN;
  localparam int unsigned WIN_W   = $clog2(MAX_WIN) + 1;
  localparam int unsigned RUN_W   = 8;
  localparam int unsigned WAIT_W  = 4;
  localparam int unsigned DOUT_W  = 8;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED
  } state_e;

  state_e              state_q, state_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [RUN_W-1:0]    tok_run_q, tok_run_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DOUT_W-1:0]   dout_q, dout_d;
  logic                de_q, de_d;
  logic                c0_q, c0_d;
  logic                c1_q, c1_d;
  logic                locked_q, locked_d;
  logic                bitslip_q, bitslip_d;

  logic                tok_c;
  logic [1:0]          tok_cc_c;
  logic [DOUT_W-1:0]   d_c;
  logic [DOUT_W-1:0]   q_c;

  // Control token recognition; tok_cc_c is {c1,c0}
  always_comb begin
    tok_c    = 1'b0;
    tok_cc_c = 2'b00;
    case (din)
      10'h354: begin tok_c = 1'b1; tok_cc_c = 2'b00; end
      10'h0AB: begin tok_c = 1'b1; tok_cc_c = 2'b01; end
      10'h154: begin tok_c = 1'b1; tok_cc_c = 2'b10; end
      10'h2AB: begin tok_c = 1'b1; tok_cc_c = 2'b11; end
      default: ;
    endcase
  end

  // Undo transition-minimising XOR/XNOR chain and optional inversion
  always_comb begin
    d_c    = din[9] ? ~din[7:0] : din[7:0];
    q_c    = '0;
    q_c[0] = d_c[0];
    for (int i = 1; i < 8; i++) begin
      q_c[i] = din[8] ? (d_c[i] ^ d_c[i-1]) : ~(d_c[i] ^ d_c[i-1]);
    end
  end

  // Alignment FSM, counters and output register next-state
  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    tok_run_d  = tok_run_q;
    wait_cnt_d = wait_cnt_q;
    dout_d     = '0;
    de_d       = 1'b0;
    c0_d       = 1'b0;
    c1_d       = 1'b0;
    locked_d   = (state_q == ST_LOCKED);
    bitslip_d  = (state_q == ST_SLIP);

    if (tok_c) begin
      if (tok_run_q != '1) tok_run_d = tok_run_q + RUN_W'(1);
    end else begin
      tok_run_d = '0;
    end

    case (state_q)
      ST_SEARCH: begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
        if (tok_c && (tok_run_q == RUN_W'(TOKEN_RUN - 1))) begin
          state_d   = ST_LOCKED;
          win_cnt_d = '0;
        end else if (win_cnt_q == WIN_W'(SEARCH_WIN - 1)) begin
          state_d = ST_SLIP;
        end
      end
      ST_SLIP: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
        tok_run_d  = '0;
      end
      ST_WAIT: begin
        tok_run_d  = '0;
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
          state_d   = ST_SEARCH;
          win_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        win_cnt_d = tok_c ? '0 : (win_cnt_q + WIN_W'(1));
        if (!tok_c && (win_cnt_q == WIN_W'(LOSS_WIN - 1))) begin
          state_d   = ST_SEARCH;
          win_cnt_d = '0;
          tok_run_d = '0;
        end
        if (tok_c) begin
          c0_d   = tok_cc_c[0];
          c1_d   = tok_cc_c[1];
          dout_d = dout_q;
        end else begin
          de_d   = 1'b1;
          dout_d = q_c;
          c0_d   = c0_q;
          c1_d   = c1_q;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_SEARCH;
      win_cnt_q  <= '0;
      tok_run_q  <= '0;
      wait_cnt_q <= '0;
      dout_q     <= '0;
      de_q       <= 1'b0;
      c0_q       <= 1'b0;
      c1_q       <= 1'b0;
      locked_q   <= 1'b0;
      bitslip_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      tok_run_q  <= tok_run_d;
      wait_cnt_q <= wait_cnt_d;
      dout_q     <= dout_d;
      de_q       <= de_d;
      c0_q       <= c0_d;
      c1_q       <= c1_d;
      locked_q   <= locked_d;
      bitslip_q  <= bitslip_d;
    end
  end

  assign dout    = dout_q;
  assign de      = de_q;
  assign c0      = c0_q;
  assign c1      = c1_q;
  assign locked  = locked_q;
  assign bitslip = bitslip_q;

endmodule

// File: tb/tb_tmds10b8b_align_dec.sv
// Bench for tmds10b8b_align_dec: directed phases with random words, checked
// against a timestamp-based model of the alignment and decode rules.
module tb_tmds10b8b_align_dec;

  localparam int unsigned SW  = 64;
  localparam int unsigned TR  = 8;
  localparam int unsigned SWT = 4;
  localparam int unsigned LW  = 256;
  localparam logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [9:0] din  = 10'h000;
  logic [7:0] dout;
  logic       de, c0, c1, locked, bitslip;

  tmds10b8b_align_dec #(
    .SEARCH_WIN(SW), .TOKEN_RUN(TR), .SLIP_WAIT(SWT), .LOSS_WIN(LW)
  ) dut (
    .clk(clk), .rstn(rstn), .din(din), .dout(dout), .de(de),
    .c0(c0), .c1(c1), .locked(locked), .bitslip(bitslip)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  string phase = "reset";

  // Model: edge index, when the current search window started, token run, lock timestamps
  int   n = 0;
  int   search_start = 0;
  int   run = 0;
  int   last_tok = 0;
  int   last_slip = -100;
  bit   m_locked = 1'b0;
  logic [7:0] e_dout = 8'h00;
  logic e_de = 1'b0, e_c0 = 1'b0, e_c1 = 1'b0, e_locked = 1'b0, e_bitslip = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit tok_lookup(input logic [9:0] w, output logic [1:0] cc);
    cc = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (w == TOK[i]) begin
        cc = 2'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] w);
    logic [7:0] d, q;
    d    = w[9] ? ~w[7:0] : w[7:0];
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = d[i] ^ d[i-1] ^ ~w[8];
    return q;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    logic [1:0] cc;
    do w = 10'($urandom_range(0, 1023)); while (tok_lookup(w, cc));
    return w;
  endfunction

  task automatic reset_model();
    m_locked  = 1'b0;
    run       = 0;
    search_start = n;
    last_slip = -100;
    e_dout = 8'h00; e_de = 1'b0; e_c0 = 1'b0; e_c1 = 1'b0;
    e_locked = 1'b0; e_bitslip = 1'b0;
  endtask

  task automatic model_edge(input logic [9:0] w);
    bit         was_locked, t;
    logic [1:0] cc;
    n++;
    if (!rstn) begin
      reset_model();
      return;
    end
    was_locked = m_locked;
    t = tok_lookup(w, cc);
    if (was_locked) begin
      if (t) begin
        e_de = 1'b0; e_c0 = cc[0]; e_c1 = cc[1];
      end else begin
        e_de = 1'b1; e_dout = decode(w);
      end
    end else begin
      e_dout = 8'h00; e_de = 1'b0; e_c0 = 1'b0; e_c1 = 1'b0;
    end
    e_locked  = was_locked;
    e_bitslip = (n == last_slip + 1);
    if (m_locked) begin
      if (t) last_tok = n;
      else if (n - last_tok == int'(LW)) begin
        m_locked = 1'b0; search_start = n; run = 0;
      end
    end else if (n > search_start) begin
      if (t && run == int'(TR) - 1) begin
        m_locked = 1'b1; last_tok = n;
      end else begin
        run = t ? run + 1 : 0;
        if (n - search_start == int'(SW)) begin
          last_slip = n; search_start = n + 1 + int'(SWT); run = 0;
        end
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic step(input logic [9:0] w);
    din = w;
    @(posedge clk);
    #1;
    model_edge(w);
    chk({phase, ".dout"},    32'(dout),    32'(e_dout));
    chk({phase, ".de"},      32'(de),      32'(e_de));
    chk({phase, ".c0"},      32'(c0),      32'(e_c0));
    chk({phase, ".c1"},      32'(c1),      32'(e_c1));
    chk({phase, ".locked"},  32'(locked),  32'(e_locked));
    chk({phase, ".bitslip"}, 32'(bitslip), 32'(e_bitslip));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    reset_model();
    repeat (2) step(rand_data());
    rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [9:0] src [0:1199];

  initial begin
    int pulses, k, off, slips, i;
    logic [19:0] pair;
    logic [9:0]  w;

    // Reset held with random input, then a static data word forces one slip
    reset_model();
    repeat (5) step(10'($urandom_range(0, 1023)));
    chk("rst.all_zero", 32'({dout, de, c0, c1, locked, bitslip}), 32'h0);
    rstn = 1'b1;
    phase = "rst_slip";
    pulses = 0;
    repeat (SW + 2) begin
      step(10'h100);
      pulses += int'(bitslip);
    end
    chk("rst_slip.pulses", 32'(pulses), 32'd1);
    chk("rst_slip.locked", 32'(locked), 32'd0);

    // Aligned lock and first decoded words
    phase = "lock";
    do_reset();
    repeat (TR) step(10'h354);
    chk("lock.not_yet", 32'(locked), 32'd0);
    step(10'h100);
    chk("lock.locked", 32'(locked), 32'd1);
    chk("lock.w0", 32'({de, dout}), 32'h100);
    step(10'h200);
    chk("lock.w1", 32'({de, dout}), 32'h1FF);
    step(10'h0AB);
    chk("lock.tok", 32'({de, c1, c0}), 32'b001);

    // Token map; dout keeps the last data value
    phase = "tokmap";
    step(10'h200);
    for (int t = 0; t < 4; t++) begin
      step(TOK[t]);
      chk("tokmap.c1c0", 32'({c1, c0}), 32'(t));
      chk("tokmap.de", 32'(de), 32'd0);
      chk("tokmap.dout", 32'(dout), 32'hFF);
    end

    // Random locked traffic
    phase = "rand";
    repeat (200) begin
      if ($urandom_range(0, 3) == 0) step(TOK[$urandom_range(0, 3)]);
      else step(rand_data());
    end

    // Loss of lock after LW data words
    phase = "loss";
    step(TOK[0]);
    repeat (LW) step(rand_data());
    chk("loss.still", 32'(locked), 32'd1);
    step(rand_data());
    chk("loss.fell", 32'(locked), 32'd0);
    i = 0;
    while (!locked && i < 40) begin
      step(TOK[0]);
      i++;
    end
    chk("loss.relock", 32'(locked), 32'd1);
    phase = "keep";
    step(TOK[1]);
    repeat (LW - 1) step(rand_data());
    step(TOK[$urandom_range(0, 3)]);
    repeat (2) step(rand_data());
    chk("keep.locked", 32'(locked), 32'd1);

    // Misaligned stream: deserializer shifts one bit per slip, starting 3 bits off
    phase = "misalign";
    for (int j = 0; j < 1200; j++) src[j] = ((j % 40) < 20) ? 10'h354 : rand_data();
    do_reset();
    k = 0; off = 3; slips = 0;
    while (!locked && k < 1100) begin
      pair = {src[k+1], src[k]};
      step(10'(pair >> off));
      if (bitslip) begin
        slips++;
        off = (off + 9) % 10;
      end
      k++;
    end
    chk("misalign.locked", 32'(locked), 32'd1);
    chk("misalign.slips", 32'(slips), 32'd3);
    repeat (40) begin
      logic [1:0] cc;
      pair = {src[k+1], src[k]};
      w = 10'(pair >> off);
      step(w);
      if (!tok_lookup(src[k], cc)) chk("misalign.src", 32'(dout), 32'(decode(src[k])));
      k++;
    end

    // Reset while in WAIT after a slip
    phase = "rstwait";
    do_reset();
    i = 0;
    while (!bitslip && i < 200) begin
      step(rand_data());
      i++;
    end
    chk("rstwait.slip_seen", 32'(bitslip), 32'd1);
    rstn = 1'b0;
    #1;
    reset_model();
    chk("rstwait.bitslip", 32'(bitslip), 32'd0);
    chk("rstwait.locked", 32'(locked), 32'd0);
    repeat (2) step(rand_data());
    rstn = 1'b1;
    pulses = 0;
    repeat (SW) begin
      step(rand_data());
      pulses += int'(bitslip);
    end
    chk("rstwait.no_pulse", 32'(pulses), 32'd0);
    i = 0;
    while (!locked && i < 120) begin
      step(TOK[$urandom_range(0, 3)]);
      i++;
    end
    chk("rstwait.relock", 32'(locked), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
